shift_hold_buffer: RTL and testbench

Parametrised, fully synchronous successor to the frame hold register. It watches an external shift clock, counts NUM_SHIFTS shift edges per frame and captures a CHANNELS×N-bit parallel word per completed frame into a DEPTH-entry holding FIFO. It presents the word to downstream logic in the sync_clk domain with a valid/ready handshake, a stretched completion strobe, overrun detection and idle-timeout frame resynchronisation. It sits between the serial-to-parallel shift registers and the sync_clk consumers.

---
 rtl/shift_hold_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 40 ++++
 rtl/shift_hold_buffer.sv | 153 +++++++++++++++
 tb/tb_shift_hold_buffer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_hold_pkg.sv
// Shared types and width helpers for the shift hold buffer.
//   edge_sel_e  : which shift_clk edge is counted
//   clog2_min1  : $clog2 with a floor of one bit, for counter widths
package shift_hold_pkg;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_sel_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus a history flop for edge detection.
// Ports:
//   clk      : sampling clock
//   reset    : asynchronous, active-high
//   async_in : signal asynchronous to clk
//   edge_det : high for one clk cycle per selected edge of async_in
module sync_edge_detect
    import shift_hold_pkg::*;
#(
    parameter edge_sel_e SHIFT_EDGE = EDGE_RISE
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic edge_det
);

    // Flops reset to the level the line idles at, so reset never fakes an edge.
    localparam logic IDLE_LVL = (SHIFT_EDGE == EDGE_FALL);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= IDLE_LVL;
            r_sync <= IDLE_LVL;
            r_prev <= IDLE_LVL;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign edge_det = (SHIFT_EDGE == EDGE_FALL) ? (r_prev & ~r_sync)
                                                : (r_sync & ~r_prev);

endmodule

// File: rtl/shift_hold_buffer.sv
// Counts shift_clk edges per frame and captures the parallel shift-register
// word at each frame completion into a small holding FIFO read in clk domain.
// Ports:
//   clk, reset (async, active-high), shift_clk (async to clk)
//   in            : CHANNELS*N parallel word, sampled at frame completion
//   out_ready     : consumer accepts head word
//   clear_overrun : synchronous clear of the overrun flag
//   out/out_valid : head word (else last popped, '1 after reset) / FIFO non-empty
//   completed_shift : STROBE_CYCLES-long strobe after each frame completion
//   overrun       : sticky, a frame was dropped on a full FIFO
//   shift_count   : edges counted in current frame
//   resync        : one-cycle pulse on mid-frame idle timeout
module shift_hold_buffer
    import shift_hold_pkg::*;
#(
    parameter int unsigned N             = 11,
    parameter int unsigned CHANNELS      = 1,
    parameter int unsigned NUM_SHIFTS    = 11,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned IDLE_TIMEOUT  = 1024,
    parameter int unsigned SHIFT_EDGE    = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              shift_clk,
    input  logic [CHANNELS*N-1:0]             in,
    input  logic                              out_ready,
    input  logic                              clear_overrun,
    output logic [CHANNELS*N-1:0]             out,
    output logic                              out_valid,
    output logic                              completed_shift,
    output logic                              overrun,
    output logic [$clog2(NUM_SHIFTS+1)-1:0]   shift_count,
    output logic                              resync
);

    localparam int unsigned W         = CHANNELS * N;
    localparam int unsigned CNT_W     = $clog2(NUM_SHIFTS + 1);
    localparam int unsigned AW        = clog2_min1(DEPTH);
    localparam int unsigned PW        = AW + 1;
    localparam int unsigned SW        = clog2_min1(STROBE_CYCLES + 1);
    localparam int unsigned IW        = clog2_min1(IDLE_TIMEOUT + 1);
    localparam bit          IDLE_EN   = (IDLE_TIMEOUT != 0);
    localparam int unsigned IDLE_LAST = IDLE_EN ? IDLE_TIMEOUT - 1 : 0;

    logic             w_edge;
    logic             w_frame_done;
    logic             w_timeout;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [PW-1:0]    w_wptr_nxt;
    logic [PW-1:0]    w_rptr_nxt;
    logic [W-1:0]     w_head_nxt;

    logic [CNT_W-1:0] r_shift_count;
    logic [IW-1:0]    r_idle;
    logic [SW-1:0]    r_strobe;
    logic             r_overrun;
    logic             r_resync;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [W-1:0]     r_out;
    logic [W-1:0]     r_mem [0:(1<<AW)-1];

    sync_edge_detect #(
        .SHIFT_EDGE ((SHIFT_EDGE != 0) ? EDGE_FALL : EDGE_RISE)
    ) u_sync_edge_detect (
        .clk      (clk),
        .reset    (reset),
        .async_in (shift_clk),
        .edge_det (w_edge)
    );

    assign w_frame_done = w_edge && (r_shift_count == CNT_W'(NUM_SHIFTS - 1));
    // An edge in the timeout cycle takes priority, so the timeout is masked.
    assign w_timeout    = IDLE_EN && !w_edge && (r_shift_count != '0)
                          && (r_idle == IW'(IDLE_LAST));

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = ((r_wptr - r_rptr) == PW'(DEPTH));
    assign w_pop      = !w_empty && out_ready;
    assign w_push     = w_frame_done && (!w_full || w_pop);
    assign w_drop     = w_frame_done && w_full && !w_pop;
    assign w_wptr_nxt = r_wptr + PW'(w_push);
    assign w_rptr_nxt = r_rptr + PW'(w_pop);

    // Head after this cycle's push/pop; the incoming word is bypassed when it
    // is the one landing in the head slot.
    assign w_head_nxt = (w_rptr_nxt == r_wptr) ? in : r_mem[w_rptr_nxt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift_count <= '0;
            r_idle        <= '0;
            r_strobe      <= '0;
            r_overrun     <= 1'b0;
            r_resync      <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_out         <= '1;
        end else begin
            if (w_edge) begin
                r_shift_count <= w_frame_done ? '0 : r_shift_count + 1'b1;
            end else if (w_timeout) begin
                r_shift_count <= '0;
            end

            if (!IDLE_EN || w_edge || w_timeout || (r_shift_count == '0)) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end

            r_resync <= w_timeout;

            if (w_frame_done) begin
                r_strobe <= SW'(STROBE_CYCLES);
            end else if (r_strobe != '0) begin
                r_strobe <= r_strobe - 1'b1;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end

            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            if (w_wptr_nxt != w_rptr_nxt) begin
                r_out <= w_head_nxt;
            end
        end
    end

    assign out             = r_out;
    assign out_valid       = !w_empty;
    assign completed_shift = (r_strobe != '0);
    assign overrun         = r_overrun;
    assign shift_count     = r_shift_count;
    assign resync          = r_resync;

endmodule

// File: tb/tb_shift_hold_buffer.sv
module tb_shift_hold_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk_a = 1'b0;
    logic        sclk_b = 1'b1;
    logic [10:0] in_a = '0;
    logic [32:0] in_b = '0;
    logic        rdy_a = 1'b0;
    logic        rdy_b = 1'b0;
    logic        clr_a = 1'b0;
    logic        clr_b = 1'b0;

    logic [10:0] out_a;
    logic        val_a, cs_a, ovr_a, rs_a;
    logic [3:0]  cnt_a;
    logic [32:0] out_b;
    logic        val_b, cs_b, ovr_b, rs_b;
    logic [3:0]  cnt_b;

    int vectors = 0;
    int miscompares = 0;
    int n_valid = 0, n_cs = 0, n_rs = 0, n_cs_b = 0;

    always #5 clk = ~clk;

    shift_hold_buffer #(
        .IDLE_TIMEOUT (64)
    ) dut (
        .clk (clk), .reset (reset), .shift_clk (sclk_a), .in (in_a),
        .out_ready (rdy_a), .clear_overrun (clr_a), .out (out_a),
        .out_valid (val_a), .completed_shift (cs_a), .overrun (ovr_a),
        .shift_count (cnt_a), .resync (rs_a)
    );

    shift_hold_buffer #(
        .CHANNELS      (3),
        .SHIFT_EDGE    (1),
        .STROBE_CYCLES (4)
    ) dut_mc (
        .clk (clk), .reset (reset), .shift_clk (sclk_b), .in (in_b),
        .out_ready (rdy_b), .clear_overrun (clr_b), .out (out_b),
        .out_valid (val_b), .completed_shift (cs_b), .overrun (ovr_b),
        .shift_count (cnt_b), .resync (rs_b)
    );

    // Cycle monitor, sampled 2 time units after the rising edge.
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            if (val_a) n_valid++;
            if (cs_a)  n_cs++;
            if (rs_a)  n_rs++;
            if (cs_b)  n_cs_b++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        n_valid = 0; n_cs = 0; n_rs = 0; n_cs_b = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_neg(2);
        reset = 1'b0;
        wait_neg(2);
    endtask

    task automatic edges_a(input int n);
        for (int i = 0; i < n; i++) begin
            sclk_a = 1'b1; wait_neg(4);
            sclk_a = 1'b0; wait_neg(4);
        end
    endtask

    task automatic edges_b(input int n);
        for (int i = 0; i < n; i++) begin
            sclk_b = 1'b0; wait_neg(4);
            sclk_b = 1'b1; wait_neg(4);
        end
    endtask

    task automatic pop_a();
        rdy_a = 1'b1; wait_neg(1); rdy_a = 1'b0;
    endtask

    // Frame-level reference model: a bounded queue of captured words.
    logic [10:0] mq[$];
    logic [10:0] m_last;
    bit          m_ovr;

    task automatic model_reset();
        mq.delete(); m_last = '1; m_ovr = 1'b0;
    endtask

    task automatic model_frame(input logic [10:0] w);
        if (mq.size() < 2) mq.push_back(w);
        else m_ovr = 1'b1;
    endtask

    task automatic model_pop();
        if (mq.size() > 0) m_last = mq.pop_front();
    endtask

    task automatic check_model(input string tag);
        check({tag, " valid"}, val_a, mq.size() != 0);
        check({tag, " out"}, out_a, (mq.size() != 0) ? mq[0] : m_last);
        check({tag, " overrun"}, ovr_a, m_ovr);
    endtask

    typedef struct {
        logic [10:0]  word;
        int unsigned  pops;
        logic         exp_valid;
        logic [10:0]  exp_out;
        logic         exp_ovr;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] w;
        int unsigned np;

        tbl[0] = '{11'h001, 32'd0, 1'b1, 11'h001, 1'b0};
        tbl[1] = '{11'h002, 32'd0, 1'b1, 11'h001, 1'b0};
        tbl[2] = '{11'h003, 32'd0, 1'b1, 11'h001, 1'b1};
        tbl[3] = '{11'h004, 32'd1, 1'b1, 11'h002, 1'b1};
        tbl[4] = '{11'h005, 32'd2, 1'b0, 11'h005, 1'b1};
        tbl[5] = '{11'h7FF, 32'd1, 1'b0, 11'h7FF, 1'b1};

        // Reset state
        wait_neg(3);
        check("rst out", out_a, 11'h7FF);
        check("rst valid", val_a, 0);
        check("rst strobe", cs_a, 0);
        check("rst overrun", ovr_a, 0);
        check("rst count", cnt_a, 0);
        check("rst resync", rs_a, 0);
        check("rst out mc", out_b, 33'h1_FFFF_FFFF);
        reset = 1'b0;
        wait_neg(2);

        // Basic frame with consumer always ready
        clear_mon();
        rdy_a = 1'b1;
        in_a = 11'h2A5;
        edges_a(11);
        wait_neg(6);
        rdy_a = 1'b0;
        check("basic valid cycles", n_valid, 1);
        check("basic strobe cycles", n_cs, 1);
        check("basic out held", out_a, 11'h2A5);
        check("basic valid after", val_a, 0);
        check("basic count", cnt_a, 0);

        // Table: frames with stalled consumer then a few pops
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_a = tbl[i].word;
            edges_a(11);
            wait_neg(4);
            for (int p = 0; p < int'(tbl[i].pops); p++) pop_a();
            wait_neg(2);
            check($sformatf("vec%0d valid", i), val_a, tbl[i].exp_valid);
            check($sformatf("vec%0d out", i), out_a, tbl[i].exp_out);
            check($sformatf("vec%0d overrun", i), ovr_a, tbl[i].exp_ovr);
        end
        clr_a = 1'b1; wait_neg(1); clr_a = 1'b0; wait_neg(1);
        check("clear overrun", ovr_a, 0);

        // Push and pop in the same cycle while full
        do_reset();
        in_a = 11'h111; edges_a(11);
        in_a = 11'h222; edges_a(11);
        wait_neg(4);
        check("full head", out_a, 11'h111);
        in_a = 11'h333;
        edges_a(10);
        sclk_a = 1'b1;
        wait_neg(2);
        rdy_a = 1'b1;   // pop lands on the same rising edge as the push
        wait_neg(1);
        rdy_a = 1'b0;
        wait_neg(3);
        sclk_a = 1'b0;
        wait_neg(4);
        check("pp overrun", ovr_a, 0);
        check("pp head2", out_a, 11'h222);
        pop_a(); wait_neg(1);
        check("pp head3", out_a, 11'h333);
        pop_a(); wait_neg(1);
        check("pp empty", val_a, 0);
        check("pp last", out_a, 11'h333);

        // Idle timeout mid-frame
        do_reset();
        clear_mon();
        in_a = 11'h000;
        edges_a(5);
        check("idle count5", cnt_a, 5);
        wait_neg(70);
        check("idle resync once", n_rs, 1);
        check("idle count0", cnt_a, 0);
        check("idle no capture", val_a, 0);
        in_a = 11'h155;
        edges_a(11);
        wait_neg(4);
        check("idle resync total", n_rs, 1);
        check("idle frame valid", val_a, 1);
        check("idle frame out", out_a, 11'h155);
        pop_a(); wait_neg(1);
        check("idle one frame", val_a, 0);

        // Multi-channel, falling edge, 4-cycle strobe
        clear_mon();
        in_b = {11'h400, 11'h7FF, 11'h001};
        edges_b(11);
        wait_neg(8);
        check("mc out", out_b, {11'h400, 11'h7FF, 11'h001});
        check("mc valid", val_b, 1);
        check("mc strobe cycles", n_cs_b, 4);
        check("mc count", cnt_b, 0);

        // Reset mid-frame with overrun set and FIFO full
        in_a = 11'h0AA; edges_a(11);
        in_a = 11'h0BB; edges_a(11);
        in_a = 11'h0CC; edges_a(11);
        wait_neg(2);
        check("pre-reset overrun", ovr_a, 1);
        edges_a(6);
        reset = 1'b1;
        wait_neg(1);
        check("mid rst out", out_a, 11'h7FF);
        check("mid rst valid", val_a, 0);
        check("mid rst strobe", cs_a, 0);
        check("mid rst overrun", ovr_a, 0);
        check("mid rst count", cnt_a, 0);
        check("mid rst resync", rs_a, 0);
        check("mid rst mc valid", val_b, 0);
        reset = 1'b0;
        wait_neg(2);
        clear_mon();
        in_a = 11'h5A5;
        edges_a(11);
        wait_neg(4);
        check("post rst valid", val_a, 1);
        check("post rst out", out_a, 11'h5A5);
        check("post rst strobe", n_cs, 1);
        check("post rst count", cnt_a, 0);
        pop_a(); wait_neg(1);
        check("post rst single", val_a, 0);

        // Randomised frames against the queue model
        do_reset();
        model_reset();
        for (int k = 0; k < 24; k++) begin
            w = 11'($urandom);
            in_a = w;
            edges_a(11);
            wait_neg(4);
            model_frame(w);
            check_model($sformatf("rnd%0d frame", k));
            np = $urandom_range(0, 2);
            for (int p = 0; p < int'(np); p++) begin
                pop_a();
                model_pop();
            end
            if ($urandom_range(0, 3) == 0) begin
                clr_a = 1'b1; wait_neg(1); clr_a = 1'b0;
                m_ovr = 1'b0;
            end
            wait_neg(2);
            check_model($sformatf("rnd%0d pop", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
